// File: rtl/palette_pkg.sv
// -----------------------------------------------------------------------------
// palette_pkg
// Shared definitions for the palette bank:
//   - pal_state_t     : init-sequencer states (ST_INIT, ST_RUN)
//   - DEFAULT_PAL     : 16-entry power-on colour table loaded into every bank
//   - TRANSPARENT_IDX : colour index reported as transparent (optional feature)
//   - default_rgb()   : default colour for any index (0 beyond the table)
// -----------------------------------------------------------------------------
package palette_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } pal_state_t;

    localparam int PAL_N           = 16;
    localparam int PAL_W           = 24;
    localparam int TRANSPARENT_IDX = 0;

    localparam logic [PAL_W-1:0] DEFAULT_PAL [PAL_N] = '{
        24'hff4295, 24'h321a07, 24'hc7ab62, 24'hae3f00,
        24'h756332, 24'hf6f2cf, 24'ha08548, 24'h000000,
        24'h000000, 24'h000000, 24'h000000, 24'h000000,
        24'h000000, 24'h000000, 24'h000000, 24'h000000
    };

    // Indexes past the table (wide IDX_W builds) default to black.
    function automatic logic [PAL_W-1:0] default_rgb(input logic [31:0] idx);
        return (idx < 32'd16) ? DEFAULT_PAL[idx[3:0]] : '0;
    endfunction

endpackage

// File: rtl/palette_ram.sv
// -----------------------------------------------------------------------------
// palette_ram
// Simple dual-port synchronous RAM, read-first (a read and write to the same
// address on the same edge returns the old word). No reset on the array so it
// maps onto block RAM.
//   i_clk            clock
//   i_we/i_waddr/i_wdata   write port
//   i_re/i_raddr          read port (address registered internally)
//   o_rdata          read data, valid the cycle after i_re
// -----------------------------------------------------------------------------
module palette_ram #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 24,
    parameter int AW    = 6
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
        if (i_re)
            r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/palette_bank.sv
// -----------------------------------------------------------------------------
// palette_bank
// Multi-bank colour palette: {rd_bank, rd_index} -> RGB with a 2-cycle
// registered read pipeline. After reset an init sequencer fills every bank
// with DEFAULT_PAL (one entry per cycle); afterwards external writes are
// accepted.
//   Clk, Reset_n (sync, active low)
//   rd_valid_i, rd_bank, rd_index  -> rd_valid_o, RGB  (latency 2)
//   wr_en, wr_bank, wr_index, wr_rgb, wr_ready
//   init_busy                      init sequencer running
//   transparent                    only with PALETTE_TRANSPARENCY_EN defined
// Optional feature macro: PALETTE_TRANSPARENCY_EN
// -----------------------------------------------------------------------------
module palette_bank
    import palette_pkg::*;
#(
    parameter  int IDX_W     = 4,
    parameter  int NUM_BANKS = 4,
    parameter  int RGB_W     = 24,
    localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              rd_valid_i,
    input  logic [BANK_W-1:0] rd_bank,
    input  logic [IDX_W-1:0]  rd_index,
    output logic              rd_valid_o,
    output logic [RGB_W-1:0]  RGB,
    input  logic              wr_en,
    input  logic [BANK_W-1:0] wr_bank,
    input  logic [IDX_W-1:0]  wr_index,
    input  logic [RGB_W-1:0]  wr_rgb,
    output logic              wr_ready,
`ifdef PALETTE_TRANSPARENCY_EN
    output logic              init_busy,
    output logic              transparent
`else
    output logic              init_busy
`endif
);

    localparam int DEPTH   = 2 ** IDX_W;
    localparam int ENTRIES = NUM_BANKS * DEPTH;
    localparam int ADDR_W  = BANK_W + IDX_W;
    localparam int STAGES  = 2;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ENTRIES - 1);
    localparam logic [BANK_W:0]   NB        = (BANK_W + 1)'(NUM_BANKS);

    // ---------------------------------------------------------------- FSM
    pal_state_t        r_state;
    pal_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_init_cnt;
    logic              w_init_we;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_INIT)
                r_init_cnt <= r_init_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: if (r_init_cnt == LAST_ADDR) w_state_nxt = ST_RUN;
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_INIT;
        endcase
    end

    always_comb begin
        init_busy = (r_state == ST_INIT);
        wr_ready  = (r_state != ST_INIT);
        // No init writes while reset is held; the counter is parked at 0.
        w_init_we = (r_state == ST_INIT) && Reset_n;
    end

    // ---------------------------------------------------------- write mux
    logic              w_wr_bank_ok;
    logic              w_ram_we;
    logic [ADDR_W-1:0] w_ram_waddr;
    logic [RGB_W-1:0]  w_ram_wdata;
    logic [RGB_W-1:0]  w_init_data;

    assign w_wr_bank_ok = ({1'b0, wr_bank} < NB);
    assign w_init_data  = RGB_W'(default_rgb(32'(r_init_cnt[IDX_W-1:0])));
    assign w_ram_we     = w_init_we || (wr_en && wr_ready && w_wr_bank_ok);
    assign w_ram_waddr  = w_init_we ? r_init_cnt  : {wr_bank, wr_index};
    assign w_ram_wdata  = w_init_we ? w_init_data : wr_rgb;

    // ---------------------------------------------------------- read path
    logic              w_rd_bank_ok;
    logic [ADDR_W-1:0] w_ram_raddr;
    logic [RGB_W-1:0]  w_ram_rdata;
    logic [STAGES-1:0] r_vld_pipe;
    logic              r_s1_zero;
    logic [RGB_W-1:0]  r_rgb;

    assign w_rd_bank_ok = ({1'b0, rd_bank} < NB);
    // Out-of-range banks read entry 0; the result is forced to 0 anyway.
    assign w_ram_raddr  = w_rd_bank_ok ? {rd_bank, rd_index} : '0;

    palette_ram #(
        .DEPTH (ENTRIES),
        .WIDTH (RGB_W),
        .AW    (ADDR_W)
    ) u_ram (
        .i_clk   (Clk),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_re    (rd_valid_i),
        .i_raddr (w_ram_raddr),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_vld_pipe <= '0;
            r_s1_zero  <= 1'b0;
            r_rgb      <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[STAGES-2:0], rd_valid_i};
            // Requests issued during init (including its last cycle) or to a
            // nonexistent bank return black.
            r_s1_zero  <= init_busy || !w_rd_bank_ok;
            // RGB holds its last value when no result emerges.
            if (r_vld_pipe[0])
                r_rgb <= r_s1_zero ? '0 : w_ram_rdata;
        end
    end

    assign rd_valid_o = r_vld_pipe[STAGES-1];
    assign RGB        = r_rgb;

`ifdef PALETTE_TRANSPARENCY_EN
    logic [IDX_W-1:0] r_s1_idx;
    logic             r_transp;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_s1_idx <= '0;
            r_transp <= 1'b0;
        end else begin
            r_s1_idx <= rd_index;
            r_transp <= r_vld_pipe[0] && (r_s1_idx == IDX_W'(TRANSPARENT_IDX));
        end
    end

    assign transparent = r_transp;
`endif

endmodule

// File: tb/tb_palette_bank.sv
module tb_palette_bank;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        rd_valid_i = 1'b0;
    logic [1:0]  rd_bank = '0;
    logic [3:0]  rd_index = '0;
    logic        rd_valid_o;
    logic [23:0] RGB;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_bank = '0;
    logic [3:0]  wr_index = '0;
    logic [23:0] wr_rgb = '0;
    logic        wr_ready;
    logic        init_busy;
`ifdef PALETTE_TRANSPARENCY_EN
    logic        transparent;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    palette_bank dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .rd_valid_i  (rd_valid_i),
        .rd_bank     (rd_bank),
        .rd_index    (rd_index),
        .rd_valid_o  (rd_valid_o),
        .RGB         (RGB),
        .wr_en       (wr_en),
        .wr_bank     (wr_bank),
        .wr_index    (wr_index),
        .wr_rgb      (wr_rgb),
        .wr_ready    (wr_ready),
`ifdef PALETTE_TRANSPARENCY_EN
        .init_busy   (init_busy),
        .transparent (transparent)
`else
        .init_busy   (init_busy)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic rd_req(input logic [1:0] b, input logic [3:0] i);
        rd_valid_i = 1'b1;
        rd_bank    = b;
        rd_index   = i;
    endtask

    // Issue one lookup, wait the 2-cycle latency, check valid and colour.
    task automatic rd_chk(input string tag, input logic [1:0] b, input logic [3:0] i,
                          input logic [23:0] exp);
        rd_req(b, i);
        tick();
        rd_valid_i = 1'b0;
        tick();
        chk({tag, "_vld"}, 32'(rd_valid_o), 32'd1);
        chk(tag, 32'(RGB), 32'(exp));
    endtask

    // Runs 70 cycles from reset release; counts cycles with init_busy=1.
    // With probe set, also exercises reads and a write during init.
    task automatic init_seq(input bit probe, output int busy);
        busy = 0;
        for (int k = 0; k < 70; k++) begin
            if (init_busy) busy++;
            rd_valid_i = 1'b0;
            wr_en      = 1'b0;
            if (probe) begin
                if (k == 5)  rd_req(2'd0, 4'd0);
                if (k == 7) begin
                    chk("init_rd_vld", 32'(rd_valid_o), 32'd1);
                    chk("init_rd_rgb", 32'(RGB), 32'd0);
                end
                if (k == 10) begin
                    chk("init_wr_ready", 32'(wr_ready), 32'd0);
                    wr_en    = 1'b1;
                    wr_bank  = 2'd0;
                    wr_index = 4'd1;
                    wr_rgb   = 24'habcdef;
                end
                if (k == 63) rd_req(2'd0, 4'd2);
                if (k == 64) chk("run_wr_ready", 32'(wr_ready), 32'd1);
                if (k == 65) begin
                    chk("lastinit_rd_vld", 32'(rd_valid_o), 32'd1);
                    chk("lastinit_rd_rgb", 32'(RGB), 32'd0);
                end
            end
            tick();
        end
        rd_valid_i = 1'b0;
        wr_en      = 1'b0;
    endtask

    logic [23:0] exp_pal [7] = '{24'hff4295, 24'h321a07, 24'hc7ab62, 24'hae3f00,
                                 24'h756332, 24'hf6f2cf, 24'ha08548};

    initial begin
        int busy;

        // Reset state
        repeat (3) tick();
        chk("rst_vld",   32'(rd_valid_o), 32'd0);
        chk("rst_rgb",   32'(RGB),        32'd0);
        chk("rst_busy",  32'(init_busy),  32'd1);
        chk("rst_ready", 32'(wr_ready),   32'd0);
`ifdef PALETTE_TRANSPARENCY_EN
        chk("rst_transp", 32'(transparent), 32'd0);
`endif

        // Init sequence
        Reset_n = 1'b1;
        init_seq(1'b1, busy);
        chk("init_len", 32'(busy), 32'd64);

        // Default table lookups
        rd_chk("b3_i2", 2'd3, 4'd2, 24'hc7ab62);
        rd_chk("b3_i5", 2'd3, 4'd5, 24'hf6f2cf);
        rd_chk("b3_i9", 2'd3, 4'd9, 24'h000000);
        rd_chk("init_wr_dropped", 2'd0, 4'd1, 24'h321a07);

        // Back-to-back reads 0..6 on bank 0
        for (int j = 0; j < 9; j++) begin
            rd_valid_i = 1'b0;
            if (j < 7) rd_req(2'd0, 4'(j));
            if (j >= 2) begin
                chk("b2b_vld", 32'(rd_valid_o), 32'd1);
                chk("b2b_rgb", 32'(RGB), 32'(exp_pal[j-2]));
            end
            tick();
        end
        chk("b2b_end_vld", 32'(rd_valid_o), 32'd0);

        // Same-cycle read/write collision returns old data
        wr_en = 1'b1; wr_bank = 2'd1; wr_index = 4'd3; wr_rgb = 24'h123456;
        rd_req(2'd1, 4'd3);
        tick();
        wr_en = 1'b0;
        rd_req(2'd1, 4'd3);
        tick();
        chk("coll_old", 32'(RGB), 32'hae3f00);
        rd_req(2'd0, 4'd3);
        tick();
        chk("coll_new", 32'(RGB), 32'h123456);
        rd_valid_i = 1'b0;
        tick();
        chk("other_bank", 32'(RGB), 32'hae3f00);
        tick();

`ifdef PALETTE_TRANSPARENCY_EN
        rd_chk("tr_i0", 2'd2, 4'd0, 24'hff4295);
        chk("tr_i0_flag", 32'(transparent), 32'd1);
        rd_chk("tr_i4", 2'd2, 4'd4, 24'h756332);
        chk("tr_i4_flag", 32'(transparent), 32'd0);
`endif

        // Reset mid-stream with a read in flight
        rd_req(2'd1, 4'd3);
        tick();
        Reset_n = 1'b0;
        tick();
        chk("mrst_vld",   32'(rd_valid_o), 32'd0);
        chk("mrst_rgb",   32'(RGB),        32'd0);
        chk("mrst_busy",  32'(init_busy),  32'd1);
        chk("mrst_ready", 32'(wr_ready),   32'd0);
        Reset_n    = 1'b1;
        rd_valid_i = 1'b0;
        init_seq(1'b0, busy);
        chk("reinit_len", 32'(busy), 32'd64);
        rd_chk("restored", 2'd1, 4'd3, 24'hae3f00);
        rd_chk("b1_i0", 2'd1, 4'd0, 24'hff4295);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
